// File: rtl/hood_fan_timer_pkg.sv
// Shared definitions for the hood fan timer.
// Gear codes, display word layout and mm:ss helpers.
package hood_fan_timer_pkg;

  localparam logic [2:0] MODE_STANDBY = 3'd0;
  localparam logic [3:0] SEP_NIBBLE   = 4'hF;

  localparam int TD_SEP_HI_LSB   = 20;
  localparam int TD_MIN_TENS_LSB = 16;
  localparam int TD_MIN_ONES_LSB = 12;
  localparam int TD_SEP_LO_LSB   = 8;
  localparam int TD_SEC_TENS_LSB = 4;
  localparam int TD_SEC_ONES_LSB = 0;

  localparam logic [31:0] TD_ZERO = 32'h00F0_0F00;

  typedef struct packed {
    logic [6:0] mm;
    logic [5:0] ss;
  } mmss_t;

  function automatic mmss_t mmss_inc(mmss_t t, logic [6:0] max_mm);
    mmss_t r;
    r = t;
    if (t.ss == 6'd59) begin
      r.ss = 6'd0;
      r.mm = (t.mm == max_mm) ? 7'd0 : t.mm + 7'd1;
    end else begin
      r.ss = t.ss + 6'd1;
    end
    return r;
  endfunction

  function automatic mmss_t mmss_dec(mmss_t t);
    mmss_t r;
    r = t;
    if (t.ss == 6'd0) begin
      r.ss = 6'd59;
      r.mm = t.mm - 7'd1;
    end else begin
      r.ss = t.ss - 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hood_time_fmt.sv
// Binary mm:ss to the 32-bit display word.
// Shared by the hood timer and the clock/alarm blocks.
module hood_time_fmt
  import hood_fan_timer_pkg::*;
(
  input  logic [6:0]  mm_i,
  input  logic [5:0]  ss_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    data_o[TD_SEP_HI_LSB   +: 4] = SEP_NIBBLE;
    data_o[TD_MIN_TENS_LSB +: 4] = 4'(mm_i / 7'd10);
    data_o[TD_MIN_ONES_LSB +: 4] = 4'(mm_i % 7'd10);
    data_o[TD_SEP_LO_LSB   +: 4] = SEP_NIBBLE;
    data_o[TD_SEC_TENS_LSB +: 4] = 4'(ss_i / 6'd10);
    data_o[TD_SEC_ONES_LSB +: 4] = 4'(ss_i % 6'd10);
  end

endmodule

// File: rtl/hood_fan_timer.sv
// Hood fan gear controller with one-shot boost,
// 1 Hz prescaler, run-time counter and display word.
module hood_fan_timer
  import hood_fan_timer_pkg::*;
#(
  parameter int TICK_DIV  = 500,
  parameter int NUM_GEARS = 3,
  parameter int BOOST_SEC = 60,
  parameter int MAX_MIN   = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode_req,
  input  logic        clear_cum,
  input  logic        boost_rearm,
  output logic [2:0]  mode_act,
  output logic        boost_active,
  output logic        boost_used,
  output logic        sec_tick,
  output logic [31:0] time_data
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0] GEAR_BOOST = 3'(NUM_GEARS);
  localparam logic [2:0] GEAR_DEMOTE = 3'(NUM_GEARS - 1);
  localparam logic [6:0] MAX_MM = 7'(MAX_MIN);
  localparam mmss_t BOOST_T = '{
    mm: 7'(BOOST_SEC / 60),
    ss: 6'(BOOST_SEC % 60)
  };

  logic [PW-1:0] ps_q, ps_d;
  logic          tick_q, tick_d;
  logic [2:0]    act_q, act_d;
  logic          ba_q, ba_d;
  logic          bu_q, bu_d;
  mmss_t         cum_q, cum_d;
  mmss_t         cd_q, cd_d;
  logic [31:0]   td_q, td_d;
  mmss_t         sel;

  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    tick_d = (ps_q == PS_LAST);

    cum_d = cum_q;
    if (clear_cum)
      cum_d = '0;
    else if (tick_q && act_q != MODE_STANDBY)
      cum_d = mmss_inc(cum_q, MAX_MM);

    act_d = act_q;
    ba_d  = ba_q;
    bu_d  = bu_q;
    cd_d  = cd_q;
    if (ba_q && tick_q) begin
      cd_d = mmss_dec(cd_q);
      if (cd_d == '0) begin
        ba_d  = 1'b0;
        act_d = GEAR_DEMOTE;
      end
    end
    if (boost_rearm && !ba_q)
      bu_d = 1'b0;

    // A lower-gear request overrides a same-cycle boost expiry
    unique case (1'b1)
      (mode_req < GEAR_BOOST): begin
        act_d = mode_req;
        ba_d  = 1'b0;
      end
      (mode_req == GEAR_BOOST && !ba_q && !bu_q): begin
        act_d = GEAR_BOOST;
        ba_d  = 1'b1;
        bu_d  = 1'b1;
        cd_d  = BOOST_T;
      end
      (mode_req == GEAR_BOOST && !ba_q && bu_q): begin
        act_d = GEAR_DEMOTE;
      end
      default: ;
    endcase
  end

  assign sel = ba_q ? cd_q : cum_q;

  hood_time_fmt u_fmt (
    .mm_i   (sel.mm),
    .ss_i   (sel.ss),
    .data_o (td_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
      act_q  <= MODE_STANDBY;
      ba_q   <= 1'b0;
      bu_q   <= 1'b0;
      cum_q  <= '0;
      cd_q   <= BOOST_T;
      td_q   <= TD_ZERO;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
      act_q  <= act_d;
      ba_q   <= ba_d;
      bu_q   <= bu_d;
      cum_q  <= cum_d;
      cd_q   <= cd_d;
      td_q   <= td_d;
    end
  end

  assign mode_act     = act_q;
  assign boost_active = ba_q;
  assign boost_used   = bu_q;
  assign sec_tick     = tick_q;
  assign time_data    = td_q;

endmodule
